// File: rtl/ysyx_2022040010_shift_pipe.sv
// Elastic multi-stage barrel shifter for the RV64 EXU.
// Shift-amount bits are split across stages, LSB group first.
module ysyx_2022040010_shift_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int EN_ROT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_src,
    input  logic [XLEN-1:0]  in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SW = $clog2(XLEN);
    localparam bit HAS_W = (XLEN == 64);
    localparam bit ROT_OK = (EN_ROT != 0);

    typedef struct packed {
        logic [XLEN-1:0]  val;
        logic [SW-1:0]    amt;
        logic [2:0]       op;
        logic             word;
        logic             fill;
        logic [TAG_W-1:0] tag;
    } stg_t;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   chain;
    logic              in_fire;
    logic              word_eff;
    stg_t              pkt;
    stg_t              q   [STAGES];
    stg_t              nxt [STAGES];

    logic unused_amt;
    assign unused_amt = ^in_amt[XLEN-1:SW];

    // Amount bits owned by stage k.
    function automatic logic [SW-1:0] gmask(input int k);
        logic [SW-1:0] m;
        m = '0;
        for (int i = 0; i < SW; i++) begin
            if (i >= (k * SW) / STAGES && i < ((k + 1) * SW) / STAGES)
                m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [XLEN-1:0] step(
        input logic [XLEN-1:0] v,
        input logic [SW-1:0]   a,
        input logic [2:0]      op,
        input logic            word,
        input logic            fill
    );
        logic [2*XLEN-1:0] dv;
        logic [63:0]       dw;
        logic [31:0]       w;
        logic [31:0]       rw;
        logic [4:0]        aw;
        logic [XLEN-1:0]   r;
        r  = '0;
        rw = '0;
        dv = '0;
        dw = '0;
        w  = v[31:0];
        aw = a[4:0];
        if (word) begin
            case (op)
                3'b000: rw = w << aw;
                3'b001: rw = w >> aw;
                3'b010: begin
                    dw = {{32{fill}}, w} >> aw;
                    rw = dw[31:0];
                end
                3'b011: if (ROT_OK) begin
                    dw = {w, w} << aw;
                    rw = dw[63:32];
                end
                3'b100: if (ROT_OK) begin
                    dw = {w, w} >> aw;
                    rw = dw[31:0];
                end
                default: rw = '0;
            endcase
            r[31:0] = rw;
        end else begin
            case (op)
                3'b000: r = v << a;
                3'b001: r = v >> a;
                3'b010: begin
                    dv = {{XLEN{fill}}, v} >> a;
                    r  = dv[XLEN-1:0];
                end
                3'b011: if (ROT_OK) begin
                    dv = {v, v} << a;
                    r  = dv[2*XLEN-1:XLEN];
                end
                3'b100: if (ROT_OK) begin
                    dv = {v, v} >> a;
                    r  = dv[XLEN-1:0];
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic stg_t stage_fn(input stg_t s, input int k);
        stg_t r;
        r     = s;
        r.val = step(s.val, s.amt & gmask(k), s.op, s.word, s.fill);
        r.amt = s.amt & ~gmask(k);
        if (k == STAGES - 1 && s.word) begin
            for (int i = 32; i < XLEN; i++) r.val[i] = r.val[31];
        end
        return r;
    endfunction

    assign word_eff = HAS_W & in_word;

    always_comb begin
        pkt      = '0;
        pkt.val  = in_src;
        pkt.amt  = in_amt[SW-1:0];
        if (word_eff) begin
            for (int i = 5; i < SW; i++) pkt.amt[i] = 1'b0;
        end
        pkt.op   = in_op;
        pkt.word = word_eff;
        pkt.fill = word_eff ? in_src[31] : in_src[XLEN-1];
        pkt.tag  = in_tag;
    end

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stg
        stg_t src;
        if (k == 0) begin : g_first
            assign src = pkt;
        end else begin : g_rest
            assign src = q[k-1];
        end
        assign nxt[k] = stage_fn(src, k);
    end

    // Stage k moves when its successor is empty or itself moving.
    always_comb begin
        logic open;
        adv  = '0;
        open = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = vld[i] & open;
            open   = ~vld[i] | adv[i];
        end
    end

    assign in_ready = ~flush & (~vld[0] | adv[0]);
    assign in_fire  = in_valid & in_ready;
    assign chain    = {adv, in_fire};
    assign load     = chain[STAGES-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) q[i] <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (!vld[i] || adv[i]) begin
                    vld[i] <= load[i];
                    if (load[i]) q[i] <= nxt[i];
                end
            end
        end
    end

    assign out_valid  = vld[STAGES-1];
    assign out_result = q[STAGES-1].val;
    assign out_tag    = q[STAGES-1].tag;

endmodule

// File: tb/tb_ysyx_2022040010_shift_pipe.sv
// Directed and streaming checks for the pipelined barrel shifter.
module tb_ysyx_2022040010_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_src = '0;
    logic [63:0] in_amt = '0;
    logic [2:0]  in_op = '0;
    logic        in_word = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    ysyx_2022040010_shift_pipe #(
        .XLEN(64), .STAGES(2), .TAG_W(5), .EN_ROT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_amt(in_amt), .in_op(in_op),
        .in_word(in_word), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bitwise reference, independent of any shifter idiom.
    function automatic logic [63:0] model(
        input logic [2:0] op, input logic word,
        input logic [63:0] src, input logic [63:0] amt
    );
        int n;
        int s;
        logic [63:0] x;
        logic [63:0] r;
        logic fill;
        n = word ? 32 : 64;
        s = word ? int'(amt[4:0]) : int'(amt[5:0]);
        x = word ? {32'b0, src[31:0]} : src;
        fill = x[n-1];
        r = '0;
        for (int i = 0; i < n; i++) begin
            case (op)
                3'd0: r[i] = (i >= s) ? x[i-s] : 1'b0;
                3'd1: r[i] = (i + s < n) ? x[i+s] : 1'b0;
                3'd2: r[i] = (i + s < n) ? x[i+s] : fill;
                3'd3: r[i] = x[(i - s + n) % n];
                3'd4: r[i] = x[(i + s) % n];
                default: r[i] = 1'b0;
            endcase
        end
        if (word) begin
            for (int i = 32; i < 64; i++) r[i] = r[31];
        end
        return r;
    endfunction

    task automatic run_one(
        input string nm, input logic [2:0] op, input logic word,
        input logic [63:0] src, input logic [63:0] amt,
        input logic [4:0] tag, input logic [63:0] exp
    );
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_op = op;
        in_word = word;
        in_src = src;
        in_amt = amt;
        in_tag = tag;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready got %b want 1", nm, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early out_valid got %b want 0", nm, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp || out_tag !== tag) begin
            errors++;
            $display("FAIL %s got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                     nm, out_valid, out_result, out_tag, exp, tag);
        end
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_out got v=%b r=%h t=%0d want 0 0 0",
                     out_valid, out_result, out_tag);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_basic();
        run_one("sll63", 3'd0, 1'b0, 64'h1, 64'd63, 5'd1, 64'h8000000000000000);
        run_one("sra4", 3'd2, 1'b0, 64'h8000000000000000, 64'd4, 5'd2,
                64'hF800000000000000);
        run_one("srl4", 3'd1, 1'b0, 64'h8000000000000000, 64'd4, 5'd3,
                64'h0800000000000000);
        run_one("sra_pos", 3'd2, 1'b0, 64'h7000000000000000, 64'd60, 5'd4,
                64'h7);
    endtask

    task automatic test_word();
        run_one("sllw31", 3'd0, 1'b1, 64'h1, 64'd31, 5'd5, 64'hFFFFFFFF80000000);
        run_one("srlw1", 3'd1, 1'b1, 64'hFFFFFFFF80000000, 64'd1, 5'd6,
                64'h0000000040000000);
        run_one("sraw4", 3'd2, 1'b1, 64'h80000000, 64'd4, 5'd7,
                64'hFFFFFFFFF8000000);
        run_one("srlw0", 3'd1, 1'b1, 64'h80000000, 64'd0, 5'd8,
                64'hFFFFFFFF80000000);
    endtask

    task automatic test_mask_rot();
        run_one("sll64", 3'd0, 1'b0, 64'h123456789ABCDEF0, 64'd64, 5'd9,
                64'h123456789ABCDEF0);
        run_one("sllw33", 3'd0, 1'b1, 64'h1, 64'h21, 5'd10, 64'h2);
        run_one("ror1", 3'd4, 1'b0, 64'h1, 64'd1, 5'd11, 64'h8000000000000000);
        run_one("rorw1", 3'd4, 1'b1, 64'h1, 64'd1, 5'd12, 64'hFFFFFFFF80000000);
        run_one("rol4", 3'd3, 1'b0, 64'h8000000000000001, 64'd4, 5'd13, 64'h18);
        run_one("rolw4", 3'd3, 1'b1, 64'hFFFF000080000001, 64'd4, 5'd14, 64'h18);
        run_one("resv", 3'd7, 1'b0, 64'hDEADBEEF, 64'd3, 5'd27, 64'h0);
    endtask

    task automatic test_backpressure();
        int acc;
        int cur;
        logic fire;
        acc = 0;
        cur = 1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd0;
        in_word = 1'b0;
        in_amt = 64'd0;
        in_src = 64'(cur);
        in_tag = 5'(cur);
        for (int c = 0; c < 6; c++) begin
            #1;
            fire = in_valid && in_ready;
            tick();
            if (fire) begin
                acc++;
                cur++;
                in_src = 64'(cur);
                in_tag = 5'(cur);
            end
        end
        #1;
        checks++;
        if (acc != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall got acc=%0d rdy=%b want 2 0", acc, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1) begin
            errors++;
            $display("FAIL bp_hold got v=%b t=%0d want 1 1", out_valid, out_tag);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 5'(i + 1) ||
                out_result !== 64'(i + 1)) begin
                errors++;
                $display("FAIL bp_drain%0d got v=%b t=%0d r=%h want v=1 t=%0d",
                         i, out_valid, out_tag, out_result, i + 1);
            end
            fire = in_valid && in_ready;
            tick();
            if (fire) begin
                acc++;
                cur++;
                if (cur > 4) begin
                    in_valid = 1'b0;
                end else begin
                    in_src = 64'(cur);
                    in_tag = 5'(cur);
                end
            end
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc != 4) begin
            errors++;
            $display("FAIL bp_end got v=%b acc=%0d want 0 4", out_valid, acc);
        end
        tick();
    endtask

    task automatic rand_input(input int n);
        in_op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                            : 3'($urandom_range(0, 4));
        in_word = 1'($urandom_range(0, 1));
        in_src = {$urandom, $urandom};
        in_amt = {$urandom, $urandom};
        in_tag = 5'(n);
    endtask

    task automatic test_streaming();
        logic [68:0] q[$];
        logic [68:0] e;
        int sent;
        int recv;
        int cyc;
        logic fire;
        sent = 0;
        recv = 0;
        cyc = 0;
        rand_input(0);
        in_valid = 1'b1;
        while (recv < 100 && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got t=%0d r=%h want none",
                             out_tag, out_result);
                end else begin
                    e = q.pop_front();
                    if (out_result !== e[63:0] || out_tag !== e[68:64]) begin
                        errors++;
                        $display("FAIL stream%0d got r=%h t=%0d want r=%h t=%0d",
                                 recv, out_result, out_tag, e[63:0], e[68:64]);
                    end
                end
                recv++;
            end
            fire = in_valid && in_ready;
            if (fire) q.push_back({in_tag, model(in_op, in_word, in_src, in_amt)});
            tick();
            cyc++;
            if (fire) begin
                sent++;
                if (sent < 100) rand_input(sent);
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (recv != 100 || q.size() != 0) begin
            errors++;
            $display("FAIL stream_count got recv=%0d left=%0d want 100 0",
                     recv, q.size());
        end
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd0;
        in_word = 1'b0;
        in_src = 64'h5;
        in_amt = 64'd1;
        in_tag = 5'd7;
        tick();
        in_tag = 5'd8;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd7) begin
            errors++;
            $display("FAIL flush_pre got v=%b t=%0d want 1 7", out_valid, out_tag);
        end
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_tag = 5'd9;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_rdy got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_next got v=%b want 0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drain%0d got v=%b t=%0d want 0",
                         i, out_valid, out_tag);
            end
        end
        run_one("post_flush", 3'd1, 1'b0, 64'hF0, 64'd4, 5'd15, 64'hF);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd0;
        in_word = 1'b0;
        in_src = 64'h3;
        in_amt = 64'd2;
        in_tag = 5'd3;
        tick();
        in_tag = 5'd4;
        tick();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL areset got v=%b r=%h t=%0d want 0 0 0",
                     out_valid, out_result, out_tag);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_rel got rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle got v=%b want 0", out_valid);
        end
        run_one("post_reset", 3'd0, 1'b0, 64'h3, 64'd2, 5'd16, 64'hC);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_word();
        test_mask_rot();
        test_backpressure();
        test_streaming();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
